// File: rtl/sys_cfg_pkg.sv
// ============================================================================
//  sys_cfg_pkg
//  Shared constants and index helpers for the system config register file.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package sys_cfg_pkg;

  localparam int ERR_CNT_W       = 16;
  localparam int ILLEGAL_RD_DATA = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int stat_base(input int num_ctrl);
    return num_ctrl;
  endfunction

  function automatic int err_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat;
  endfunction

  function automatic int commit_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sys_cfg_byte_reg.sv
// ============================================================================
//  sys_cfg_byte_reg
//  One data word with per-byte-lane write enables and a reset value.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sys_cfg_byte_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BYTE_NUM   = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_NUM-1:0]   i_we,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_q
);

  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else begin
      for (int b = 0; b < BYTE_NUM; b++) begin
        if (i_we[b]) r_q[b*8 +: 8] <= i_din[b*8 +: 8];
      end
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/sys_cfg_regfile.sv
// ============================================================================
//  sys_cfg_regfile
//  BRAM-port config register file: RW control, RO status, error counter.
//  Optional shadow/commit staging when SYS_CFG_SHADOW_EN is defined.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sys_cfg_regfile
  import sys_cfg_pkg::*;
#(
  parameter int                             ADDR_WIDTH = 32,
  parameter int                             DATA_WIDTH = 32,
  parameter int                             BYTE_NUM   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0]          BASE_ADDR  = '0,
  parameter int                             NUM_CTRL   = 8,
  parameter int                             NUM_STAT   = 4,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RST   = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bram_en,
  input  logic [BYTE_NUM-1:0]            bram_we,
  input  logic [ADDR_WIDTH-1:0]          bram_addr,
  input  logic [DATA_WIDTH-1:0]          bram_din,
  output logic [DATA_WIDTH-1:0]          bram_dout,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] ctrl_regs,
  output logic [NUM_CTRL-1:0]            ctrl_wr_pulse,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_regs,
  output logic [ERR_CNT_W-1:0]           err_cnt
);

  localparam int                    c_lsb       = clog2(BYTE_NUM);
  localparam logic [ADDR_WIDTH-1:0] c_stat_base = ADDR_WIDTH'(stat_base(NUM_CTRL));
  localparam logic [ADDR_WIDTH-1:0] c_err_idx   = ADDR_WIDTH'(err_idx(NUM_CTRL, NUM_STAT));

  logic [ADDR_WIDTH:0]                  w_diff;
  logic [ADDR_WIDTH-1:0]                w_idx;
  logic                                 w_below, w_wr, w_rd;
  logic                                 w_in_ctrl, w_in_stat, w_in_err;
  logic                                 w_legal, w_illegal, w_clr;
  logic [NUM_CTRL-1:0][BYTE_NUM-1:0]    w_lane_we;
  logic [NUM_CTRL-1:0]                  w_ctrl_hit;
  logic [NUM_CTRL*DATA_WIDTH-1:0]       w_view;
  logic [DATA_WIDTH-1:0]                w_rd_data;
  logic [ERR_CNT_W-1:0]                 r_err_cnt;
  logic [DATA_WIDTH-1:0]                r_dout;
  logic [NUM_CTRL-1:0]                  r_pulse;

  // The extra MSB of the subtraction is the borrow: set when below BASE_ADDR.
  assign w_diff    = {1'b0, bram_addr} - {1'b0, BASE_ADDR};
  assign w_below   = w_diff[ADDR_WIDTH];
  assign w_idx     = w_diff[ADDR_WIDTH-1:0] >> c_lsb;
  assign w_wr      = bram_en && (bram_we != '0);
  assign w_rd      = bram_en && (bram_we == '0);
  assign w_in_ctrl = !w_below && (w_idx < c_stat_base);
  assign w_in_stat = !w_below && (w_idx >= c_stat_base) && (w_idx < c_err_idx);
  assign w_in_err  = !w_below && (w_idx == c_err_idx);
  assign w_clr     = w_wr && w_in_err;
  assign w_illegal = bram_en && !w_legal;

`ifdef SYS_CFG_SHADOW_EN
  localparam logic [ADDR_WIDTH-1:0] c_cmt_idx = ADDR_WIDTH'(commit_idx(NUM_CTRL, NUM_STAT));
  logic                w_in_cmt, w_commit;
  logic [NUM_CTRL-1:0] r_dirty;

  assign w_in_cmt = !w_below && (w_idx == c_cmt_idx);
  assign w_commit = w_wr && w_in_cmt && bram_din[0];
  assign w_legal  = w_in_ctrl || w_in_err || w_in_cmt || (w_in_stat && w_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dirty <= '0;
      r_pulse <= '0;
    end else begin
      r_dirty <= w_commit ? '0 : (r_dirty | w_ctrl_hit);
      r_pulse <= w_commit ? r_dirty : '0;
    end
  end
`else
  assign w_legal = w_in_ctrl || w_in_err || (w_in_stat && w_rd);

  always_ff @(posedge clk) begin
    if (rst) r_pulse <= '0;
    else     r_pulse <= w_ctrl_hit;
  end
`endif

  always_comb begin
    for (int i = 0; i < NUM_CTRL; i++) begin
      w_lane_we[i]  = (w_wr && w_in_ctrl && (w_idx == ADDR_WIDTH'(i))) ? bram_we : '0;
      w_ctrl_hit[i] = |w_lane_we[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
`ifdef SYS_CFG_SHADOW_EN
      logic [DATA_WIDTH-1:0] w_shadow;
      sys_cfg_byte_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_NUM   (BYTE_NUM),
        .RST_VAL    (CTRL_RST[gi*DATA_WIDTH +: DATA_WIDTH])
      ) u_shadow (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_lane_we[gi]),
        .i_din (bram_din),
        .o_q   (w_shadow)
      );
      sys_cfg_byte_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_NUM   (BYTE_NUM),
        .RST_VAL    (CTRL_RST[gi*DATA_WIDTH +: DATA_WIDTH])
      ) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .i_we  ({BYTE_NUM{w_commit}}),
        .i_din (w_shadow),
        .o_q   (ctrl_regs[gi*DATA_WIDTH +: DATA_WIDTH])
      );
      assign w_view[gi*DATA_WIDTH +: DATA_WIDTH] = w_shadow;
`else
      sys_cfg_byte_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_NUM   (BYTE_NUM),
        .RST_VAL    (CTRL_RST[gi*DATA_WIDTH +: DATA_WIDTH])
      ) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_lane_we[gi]),
        .i_din (bram_din),
        .o_q   (ctrl_regs[gi*DATA_WIDTH +: DATA_WIDTH])
      );
      assign w_view[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_regs[gi*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  endgenerate

  always_comb begin
    w_rd_data = DATA_WIDTH'(ILLEGAL_RD_DATA);
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (w_in_ctrl && (w_idx == ADDR_WIDTH'(i))) w_rd_data = w_view[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (w_in_stat && (w_idx == c_stat_base + ADDR_WIDTH'(j)))
        w_rd_data = stat_regs[j*DATA_WIDTH +: DATA_WIDTH];
    end
    if (w_in_err) w_rd_data = DATA_WIDTH'(r_err_cnt);
`ifdef SYS_CFG_SHADOW_EN
    if (w_in_cmt) w_rd_data = DATA_WIDTH'(r_dirty);
`endif
  end

  // A clearing write outranks any simultaneous increment.
  always_ff @(posedge clk) begin
    if (rst)                                  r_err_cnt <= '0;
    else if (w_clr)                           r_err_cnt <= '0;
    else if (w_illegal && (r_err_cnt != '1))  r_err_cnt <= r_err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_dout <= '0;
    else if (w_rd) r_dout <= w_illegal ? DATA_WIDTH'(ILLEGAL_RD_DATA) : w_rd_data;
  end

  assign bram_dout     = r_dout;
  assign ctrl_wr_pulse = r_pulse;
  assign err_cnt       = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sys_cfg_regfile.sv
// ============================================================================
//  tb_sys_cfg_regfile
//  Self-checking bench with a read-data scoreboard and a register model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sys_cfg_regfile;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BN = 4;
  localparam int NC = 8;
  localparam int NS = 4;
  localparam int E  = NC + NS;
  localparam logic [NC*DW-1:0] RSTV = {32'h0, 32'h0, 32'h0000_BEEF, 32'h0,
                                       32'h0, 32'h0, 32'h0, 32'hA5A5_0001};

  logic              clk = 1'b0;
  logic              rst;
  logic              bram_en;
  logic [BN-1:0]     bram_we;
  logic [AW-1:0]     bram_addr;
  logic [DW-1:0]     bram_din;
  logic [DW-1:0]     bram_dout;
  logic [NC*DW-1:0]  ctrl_regs;
  logic [NC-1:0]     ctrl_wr_pulse;
  logic [NS*DW-1:0]  stat_regs;
  logic [15:0]       err_cnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_ctrl [NC];
  logic [DW-1:0] m_shad [NC];
  logic [NC-1:0] m_dirty;
  logic [NC-1:0] m_pulse;
  int            m_err;
  logic [DW-1:0] m_dout;
  logic          m_rd;
  logic [DW-1:0] q_rd [$];
  logic [DW-1:0] exp_rd;

  sys_cfg_regfile #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BYTE_NUM   (BN),
    .BASE_ADDR  (32'h0),
    .NUM_CTRL   (NC),
    .NUM_STAT   (NS),
    .CTRL_RST   (RSTV)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_dout     (bram_dout),
    .ctrl_regs     (ctrl_regs),
    .ctrl_wr_pulse (ctrl_wr_pulse),
    .stat_regs     (stat_regs),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [NC*DW-1:0] pack_ctrl();
    logic [NC*DW-1:0] p;
    for (int i = 0; i < NC; i++) p[i*DW +: DW] = m_ctrl[i];
    return p;
  endfunction

  task automatic model_reset();
    logic [NC*DW-1:0] rv;
    rv = RSTV;
    for (int i = 0; i < NC; i++) begin
      m_ctrl[i] = rv[i*DW +: DW];
      m_shad[i] = rv[i*DW +: DW];
    end
    m_dirty = '0;
    m_pulse = '0;
    m_err   = 0;
    m_dout  = '0;
    q_rd.delete();
  endtask

  task automatic model(input logic [BN-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    int            idx;
    logic [DW-1:0] rd;
    idx     = int'(addr >> 2);
    rd      = '0;
    m_pulse = '0;
    m_rd    = (we == '0);
    if (idx < NC) begin
      rd = m_shad[idx];
      for (int b = 0; b < BN; b++) if (we[b]) m_shad[idx][b*8 +: 8] = din[b*8 +: 8];
      if (!m_rd) begin
`ifdef SYS_CFG_SHADOW_EN
        m_dirty[idx] = 1'b1;
`else
        m_ctrl[idx]  = m_shad[idx];
        m_pulse[idx] = 1'b1;
`endif
      end
    end else if (idx < E) begin
      if (m_rd) rd = stat_regs[(idx-NC)*DW +: DW];
      else if (m_err < 65535) m_err++;
    end else if (idx == E) begin
      if (m_rd) rd = DW'(m_err);
      else m_err = 0;
`ifdef SYS_CFG_SHADOW_EN
    end else if (idx == E + 1) begin
      if (m_rd) rd = DW'(m_dirty);
      else if (din[0]) begin
        for (int i = 0; i < NC; i++) m_ctrl[i] = m_shad[i];
        m_pulse = m_dirty;
        m_dirty = '0;
      end
`endif
    end else begin
      if (m_err < 65535) m_err++;
    end
    if (m_rd) begin
      q_rd.push_back(rd);
      m_dout = rd;
    end
  endtask

  // Drive one access at the current negedge; return at the next negedge.
  task automatic access(input logic [BN-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    bram_en   = 1'b1;
    bram_we   = we;
    bram_addr = addr;
    bram_din  = din;
    @(negedge clk);
    bram_en   = 1'b0;
    bram_we   = '0;
  endtask

  task automatic step(input logic [BN-1:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    model(we, addr, din);
    access(we, addr, din);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ctrl_regs[31:0] !== 32'hA5A5_0001) begin errors++; $display("FAIL rst_reg0 got %h exp %h", ctrl_regs[31:0], 32'hA5A5_0001); end
    checks++; if (ctrl_regs !== RSTV) begin errors++; $display("FAIL rst_ctrl got %h exp %h", ctrl_regs, RSTV); end
    checks++; if (bram_dout !== '0) begin errors++; $display("FAIL rst_dout got %h exp 0", bram_dout); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL rst_err got %h exp 0", err_cnt); end
    checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL rst_pulse got %b exp 0", ctrl_wr_pulse); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_byte_write();
    step(4'b0101, 32'h8, 32'h1122_3344);
    checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL bw_ctrl got %h exp %h", ctrl_regs, pack_ctrl()); end
    checks++; if (ctrl_wr_pulse !== m_pulse) begin errors++; $display("FAIL bw_pulse got %b exp %b", ctrl_wr_pulse, m_pulse); end
    @(negedge clk);
    checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL bw_pulse_end got %b exp 0", ctrl_wr_pulse); end
    step('0, 32'h8, 32'h0);
    exp_rd = q_rd.pop_front();
    checks++; if (bram_dout !== 32'h0022_0044) begin errors++; $display("FAIL bw_read got %h exp %h", bram_dout, 32'h0022_0044); end
    checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL bw_read_sb got %h exp %h", bram_dout, exp_rd); end
    step('0, 32'h17, 32'h0);
    exp_rd = q_rd.pop_front();
    checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL low_bits_read got %h exp %h", bram_dout, exp_rd); end
    step(4'hF, 32'h4, 32'hDEAD_BEEF);
    checks++; if (bram_dout !== m_dout) begin errors++; $display("FAIL wr_hold_dout got %h exp %h", bram_dout, m_dout); end
    checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL wr_full got %h exp %h", ctrl_regs, pack_ctrl()); end
  endtask

  task automatic test_status();
    stat_regs = {32'h4444_0003, 32'h3333_0002, 32'hCAFE_F00D, 32'h1111_0000};
    step('0, 32'h24, 32'h0);
    exp_rd = q_rd.pop_front();
    checks++; if (bram_dout !== 32'hCAFE_F00D) begin errors++; $display("FAIL stat_read got %h exp %h", bram_dout, 32'hCAFE_F00D); end
    checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL stat_read_sb got %h exp %h", bram_dout, exp_rd); end
    step(4'hF, 32'h24, 32'h1234_5678);
    checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL stat_wr_err got %0d exp %0d", err_cnt, m_err); end
    checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL stat_wr_ctrl got %h exp %h", ctrl_regs, pack_ctrl()); end
    checks++; if (bram_dout !== m_dout) begin errors++; $display("FAIL stat_wr_dout got %h exp %h", bram_dout, m_dout); end
  endtask

  task automatic test_err_count();
    step(4'h1, 32'h30, 32'h0);
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL err_clr0 got %0d exp 0", err_cnt); end
    for (int k = 1; k <= 3; k++) begin
      step('0, 32'h100, 32'h0);
      exp_rd = q_rd.pop_front();
      checks++; if (err_cnt !== 16'(k)) begin errors++; $display("FAIL err_inc got %0d exp %0d", err_cnt, k); end
      checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL oor_read got %h exp %h", bram_dout, exp_rd); end
    end
    step('0, 32'h30, 32'h0);
    exp_rd = q_rd.pop_front();
    checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL err_read got %h exp %h", bram_dout, exp_rd); end
    step(4'h8, 32'h30, 32'hFFFF_FFFF);
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL err_clr got %0d exp 0", err_cnt); end
    step(4'hF, 32'h34, 32'h1);
    checks++; if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL cmt_idx_err got %0d exp %0d", err_cnt, m_err); end
    bram_en = 1'b1; bram_we = '0; bram_addr = 32'h200;
    repeat (65540) @(negedge clk);
    bram_en = 1'b0;
    m_err = 65535; m_dout = '0;
    checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL err_sat got %h exp ffff", err_cnt); end
    step(4'h2, 32'h30, 32'h0);
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL err_sat_clr got %0d exp 0", err_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [BN-1:0] t_we   [7] = '{4'hF, 4'h8, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [AW-1:0] t_addr [7] = '{32'h0, 32'h4, 32'hC, 32'h0, 32'h4, 32'hC, 32'h14};
    logic [DW-1:0] t_din  [7] = '{32'h0101_0101, 32'hAB00_0000, 32'h0000_5A5A, 32'h0, 32'h0, 32'h0, 32'h0};
    for (int s = 0; s < 7; s++) begin
      step(t_we[s], t_addr[s], t_din[s]);
      checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL b2b_ctrl[%0d] got %h exp %h", s, ctrl_regs, pack_ctrl()); end
      checks++; if (ctrl_wr_pulse !== m_pulse) begin errors++; $display("FAIL b2b_pulse[%0d] got %b exp %b", s, ctrl_wr_pulse, m_pulse); end
      if (m_rd) begin
        exp_rd = q_rd.pop_front();
        checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL b2b_read[%0d] got %h exp %h", s, bram_dout, exp_rd); end
      end
    end
  endtask

`ifdef SYS_CFG_SHADOW_EN
  task automatic test_shadow();
    step(4'hF, 32'h34, 32'h1);
    step(4'hF, 32'h0, 32'h1234_5678);
    step(4'hF, 32'hC, 32'h8765_4321);
    checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL sh_hold got %h exp %h", ctrl_regs, pack_ctrl()); end
    step('0, 32'h34, 32'h0);
    exp_rd = q_rd.pop_front();
    checks++; if (bram_dout !== 32'h9) begin errors++; $display("FAIL sh_dirty got %h exp 9", bram_dout); end
    step(4'hF, 32'h34, 32'h0);
    checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL sh_nocommit got %b exp 0", ctrl_wr_pulse); end
    step(4'hF, 32'h34, 32'h1);
    checks++; if (ctrl_wr_pulse !== 8'b0000_1001) begin errors++; $display("FAIL sh_pulse got %b exp 00001001", ctrl_wr_pulse); end
    checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL sh_commit got %h exp %h", ctrl_regs, pack_ctrl()); end
    step('0, 32'h34, 32'h0);
    exp_rd = q_rd.pop_front();
    checks++; if (bram_dout !== exp_rd) begin errors++; $display("FAIL sh_dirty_clr got %h exp %h", bram_dout, exp_rd); end
  endtask
`endif

  task automatic test_reset_mid_burst();
    step('0, 32'h100, 32'h0);
    step('0, 32'h14, 32'h0);
    void'(q_rd.pop_front());
    void'(q_rd.pop_front());
    step(4'hF, 32'h10, 32'h5555_AAAA);
    checks++; if (ctrl_wr_pulse !== m_pulse) begin errors++; $display("FAIL burst_pulse got %b exp %b", ctrl_wr_pulse, m_pulse); end
    rst = 1'b1;
    access(4'hF, 32'h18, 32'hFFFF_FFFF);
    model_reset();
    checks++; if (ctrl_regs !== RSTV) begin errors++; $display("FAIL mid_rst_ctrl got %h exp %h", ctrl_regs, RSTV); end
    checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL mid_rst_pulse got %b exp 0", ctrl_wr_pulse); end
    checks++; if (bram_dout !== '0) begin errors++; $display("FAIL mid_rst_dout got %h exp 0", bram_dout); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL mid_rst_err got %h exp 0", err_cnt); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ctrl_wr_pulse !== '0) begin errors++; $display("FAIL post_rst_pulse got %b exp 0", ctrl_wr_pulse); end
    checks++; if (ctrl_regs !== pack_ctrl()) begin errors++; $display("FAIL post_rst_ctrl got %h exp %h", ctrl_regs, pack_ctrl()); end
  endtask

  initial begin
    rst       = 1'b1;
    bram_en   = 1'b0;
    bram_we   = '0;
    bram_addr = '0;
    bram_din  = '0;
    stat_regs = '0;
    test_reset();
    test_byte_write();
    test_status();
    test_err_count();
    test_back_to_back();
`ifdef SYS_CFG_SHADOW_EN
    test_shadow();
`endif
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
